multi_cycle_adder: RTL and testbench

- Parametrised, multi-cycle successor to the team's single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock with the carry held in a register between chunks.
- Provides unsigned carry-out and a signed-overflow flag.
- Valid/ready handshakes on both sides, so it can sit between datapath stages where a full-width single-cycle adder misses timing.

---
 rtl/multi_cycle_adder_pkg.sv | 20 ++
 rtl/multi_cycle_adder_chunk.sv | 29 ++
 rtl/multi_cycle_adder.sv | 148 ++++++++++++++
 tb/tb_multi_cycle_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM encoding, default
// geometry and the chunk-index width helper.
package multi_cycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int NCHUNK    = DEF_WIDTH / DEF_CHUNK;

    // Width of the chunk index; a single-chunk adder still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_cycle_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// c_msb exposes the carry into the top bit so the caller can derive
// two's-complement overflow on the final chunk.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock with the
// carry registered between slices, valid/ready on both sides.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N_CHUNK = WIDTH / CHUNK;
    localparam int IDX_W   = idx_width(N_CHUNK);
    localparam int N_SLOT  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             cout_reg, overflow_reg;
    logic [CHUNK-1:0] sum_slice_reg [N_CHUNK];

    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout, chunk_c_msb;

    // Slot tables padded to a power of two so the index never selects
    // outside the array, even for a single-chunk build.
    logic [CHUNK-1:0] a_slots [N_SLOT];
    logic [CHUNK-1:0] b_slots [N_SLOT];

    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
            if (gi < N_CHUNK) begin : g_used
                assign a_slots[gi] = a_reg[gi*CHUNK +: CHUNK];
                assign b_slots[gi] = b_reg[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign a_slots[gi] = '0;
                assign b_slots[gi] = '0;
            end
        end
    endgenerate

    assign chunk_a    = a_slots[idx_reg];
    assign chunk_b    = b_slots[idx_reg];
    assign accept     = (state_reg == IDLE) && in_valid;
    assign last_chunk = (idx_reg == LAST_IDX);

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_reg),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; ready only in IDLE, valid only in DONE.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ADD;
            end
            ADD: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk index and inter-chunk carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == ADD) begin
            carry_reg <= chunk_cout;
            if (!last_chunk) idx_reg <= idx_reg + 1'b1;
        end
    end

    // Final-chunk flags: carry out of the MSB and signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if ((state_reg == ADD) && last_chunk) begin
            cout_reg     <= chunk_cout;
            overflow_reg <= chunk_c_msb ^ chunk_cout;
        end
    end

    // One register per result slice, written only while its chunk is added;
    // held through DONE and IDLE so the last result stays visible.
    generate
        for (genvar gi = 0; gi < N_CHUNK; gi++) begin : g_sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_slice_reg[gi] <= '0;
                end else if ((state_reg == ADD) && (idx_reg == IDX_W'(gi))) begin
                    sum_slice_reg[gi] <= chunk_sum;
                end
            end
            assign sum[gi*CHUNK +: CHUNK] = sum_slice_reg[gi];
        end
    endgenerate

    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench: drivers push expected results, monitors pop and compare
// on each output handshake and check accept-to-valid latency.
module tb_multi_cycle_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // 32/8 instance
    logic        in_valid = 1'b0, in_ready, cin = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, cout, overflow;

    // 16/16 single-chunk instance
    logic        in_valid2 = 1'b0, in_ready2, cin2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0, sum2;
    logic        out_valid2, out_ready2 = 1'b1, cout2, overflow2;

    typedef struct {
        string       name;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    multi_cycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    multi_cycle_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .overflow(overflow2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Drive one operation into the 32-bit DUT and push its expectation.
    task automatic send(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        bit   got;
        got = 0;
        @(posedge clk); #1;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        else begin
            e.name = name; e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1; e.lat = 4;
            q1.push_back(e);
            $display("send %s a=0x%08h b=0x%08h cin=%0d", name, va, vb, vc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q2.size() == 0 && in_ready && in_ready2) begin done = 1; break; end
        end
        if (!done) check({name, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor for the 32-bit DUT.
    bit seen1 = 0;
    always @(negedge clk) begin
        if (!rst_n) seen1 = 0;
        else if (out_valid) begin
            if (q1.size() == 0) begin
                if (!seen1) check("unexpected_out_valid", 32'd1, 32'd0);
                seen1 = 1;
            end else begin
                if (!seen1) check({q1[0].name, "_latency"}, cyc - q1[0].acc, q1[0].lat);
                seen1 = 1;
                if (out_ready) begin
                    check({q1[0].name, "_sum"}, sum, q1[0].sum);
                    check({q1[0].name, "_cout"}, {31'd0, cout}, {31'd0, q1[0].cout});
                    check({q1[0].name, "_ovf"}, {31'd0, overflow}, {31'd0, q1[0].ovf});
                    void'(q1.pop_front());
                    seen1 = 0;
                end
            end
        end
    end

    // Monitor for the single-chunk DUT.
    bit seen2 = 0;
    always @(negedge clk) begin
        if (!rst_n) seen2 = 0;
        else if (out_valid2) begin
            if (q2.size() == 0) begin
                if (!seen2) check("unexpected_out_valid2", 32'd1, 32'd0);
                seen2 = 1;
            end else begin
                if (!seen2) check({q2[0].name, "_latency"}, cyc - q2[0].acc, q2[0].lat);
                seen2 = 1;
                if (out_ready2) begin
                    check({q2[0].name, "_sum"}, {16'd0, sum2}, q2[0].sum);
                    check({q2[0].name, "_cout"}, {31'd0, cout2}, {31'd0, q2[0].cout});
                    check({q2[0].name, "_ovf"}, {31'd0, overflow2}, {31'd0, q2[0].ovf});
                    void'(q2.pop_front());
                    seen2 = 0;
                end
            end
        end
    end

    initial begin
        bit got;
        exp_t e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        send("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        send("cin_boundary", 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        send("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        wait_idle("basic");

        // Backpressure with new operands driven during the stall
        out_ready = 1'b0;
        send("stall", 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        if (!got) check("stall_valid_timeout", 32'd0, 32'd1);
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_sum_hold", sum, 32'h3333_3333);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_release_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_ready", {31'd0, in_ready}, 32'd1);
        check("stall_idle_sum_hold", sum, 32'h3333_3333);
        out_ready = 1'b1;
        wait_idle("stall");

        // Reset during ADD: the in-flight operation is discarded
        send("aborted", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        q1.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", sum, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
        wait_idle("after_rst");

        // Single-chunk configuration
        @(posedge clk); #1;
        a2 = 16'hFFFF; b2 = 16'h0001; cin2 = 1'b1; in_valid2 = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready2) begin got = 1; break; end
        end
        if (!got) check("single_accept_timeout", 32'd0, 32'd1);
        else begin
            e.name = "single"; e.sum = 32'h0000_0001; e.cout = 1'b1; e.ovf = 1'b0;
            e.acc = cyc + 1; e.lat = 1;
            q2.push_back(e);
            $display("send single a=0xffff b=0x0001 cin=1");
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        wait_idle("single");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
